// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory req/ack handshake with timeout abort, upstream
// stall, registered branch/jump redirect + flush, and the MEM/WB payload register.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        mem_aluout,
    input  logic [7:0]        mem_read_data_2,
    input  logic [ADDR_W-1:0] mem_reg_write_addr,
    input  logic [ADDR_W-1:0] mem_branch_addr,
    input  logic [ADDR_W-1:0] mem_jump_addr,
    input  logic              mem_zr,
    input  logic              mem_branch,
    input  logic              mem_branch_flip,
    input  logic              mem_jump,
    input  logic              mem_mem_read,
    input  logic              mem_mem_write,
    input  logic              mem_reg_write,
    input  logic              mem_memto_reg,
    output logic              dm_req,
    output logic              dm_we,
    output logic [7:0]        dm_addr,
    output logic [7:0]        dm_wdata,
    input  logic [7:0]        dm_rdata,
    input  logic              dm_ack,
    output logic              stall,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic [7:0]        wb_result,
    output logic [ADDR_W-1:0] wb_reg_write_addr,
    output logic              wb_reg_write,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         addr_reg, wdata_reg, alu_reg;
    logic               we_reg, rw_reg, m2r_reg;
    logic [ADDR_W-1:0]  rd_addr_reg;
    logic [7:0]         wb_result_reg;
    logic [ADDR_W-1:0]  wb_addr_reg;
    logic               wb_rw_reg;
    logic               redirect_reg;
    logic [ADDR_W-1:0]  target_reg;
    logic               bus_err_reg;

    logic               mem_op, taken, stall_int, ack_hit, timeout_hit;
    logic [ADDR_W-1:0]  target_sel;

    assign mem_op     = mem_mem_read | mem_mem_write;
    assign taken      = mem_jump | (mem_branch & (mem_zr ^ mem_branch_flip));
    assign target_sel = mem_jump ? mem_jump_addr : mem_branch_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        stall_int   = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (mem_op) begin
                    stall_int  = 1'b1;
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dm_ack) begin
                    ack_hit    = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    stall_int = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            alu_reg       <= '0;
            we_reg        <= 1'b0;
            rw_reg        <= 1'b0;
            m2r_reg       <= 1'b0;
            rd_addr_reg   <= '0;
            wb_result_reg <= '0;
            wb_addr_reg   <= '0;
            wb_rw_reg     <= 1'b0;
            redirect_reg  <= 1'b0;
            target_reg    <= '0;
            bus_err_reg   <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            cnt_reg <= '0;
            if (mem_op) begin
                // Capture the whole instruction so the access is immune to upstream changes.
                addr_reg     <= mem_aluout;
                wdata_reg    <= mem_read_data_2;
                alu_reg      <= mem_aluout;
                we_reg       <= mem_mem_write;
                rw_reg       <= mem_reg_write;
                m2r_reg      <= mem_memto_reg;
                rd_addr_reg  <= mem_reg_write_addr;
                wb_rw_reg    <= 1'b0;
                redirect_reg <= 1'b0;
            end else begin
                wb_result_reg <= mem_aluout;
                wb_addr_reg   <= mem_reg_write_addr;
                wb_rw_reg     <= mem_reg_write;
                redirect_reg  <= taken;
                if (taken) target_reg <= target_sel;
            end
        end else begin
            redirect_reg <= 1'b0;
            if (ack_hit) begin
                cnt_reg       <= '0;
                wb_result_reg <= m2r_reg ? dm_rdata : alu_reg;
                wb_addr_reg   <= rd_addr_reg;
                wb_rw_reg     <= rw_reg;
            end else if (timeout_hit) begin
                // Aborted loads write back zero rather than stale bus data.
                cnt_reg       <= '0;
                bus_err_reg   <= 1'b1;
                wb_result_reg <= we_reg ? alu_reg : 8'h00;
                wb_addr_reg   <= rd_addr_reg;
                wb_rw_reg     <= rw_reg;
            end else begin
                cnt_reg   <= cnt_reg + 1'b1;
                wb_rw_reg <= 1'b0;
            end
        end
    end

    assign dm_req            = (state_reg == S_ACCESS);
    assign dm_we             = we_reg;
    assign dm_addr           = addr_reg;
    assign dm_wdata          = wdata_reg;
    assign stall             = rst_n & stall_int;
    assign pc_redirect       = redirect_reg;
    assign flush             = redirect_reg;
    assign pc_target         = target_reg;
    assign wb_result         = wb_result_reg;
    assign wb_reg_write_addr = wb_addr_reg;
    assign wb_reg_write      = wb_rw_reg;
    assign bus_err           = bus_err_reg;

endmodule
